// File: rtl/ram24_bus_arbiter.sv
// Two-port arbiter in front of the single-port RAM24: round-robin on ties, optional
// locked bursts bounded by MAX_BURST, and one-cycle read return routed to the requester.
module ram24_bus_arbiter #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 24,
    parameter int MAX_BURST     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic                     a_lock,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]    a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [DATA_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic                     b_lock,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]    b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [DATA_WIDTH-1:0]    b_rdata,
    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = MAX_BURST[CNT_W-1:0];

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t           state;
    logic             last_b;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             a_vld_p1;
    logic             b_vld_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    assign cnt_inc = sat_inc(burst_cnt);

    // Grant depends only on requests and registered state, never on mem_dout.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst) begin
            case (state)
                OWN_A: begin
                    a_gnt = a_req;
                    b_gnt = !a_req && b_req;
                end
                OWN_B: begin
                    b_gnt = b_req;
                    a_gnt = !b_req && a_req;
                end
                default: begin
                    if (a_req && b_req) begin
                        a_gnt = last_b;
                        b_gnt = !last_b;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
            endcase
        end
    end

    assign mem_en   = a_gnt || b_gnt;
    assign mem_we   = ((a_gnt && a_we) || (b_gnt && b_we)) ? 4'b1111 : 4'b0000;
    assign mem_addr = b_gnt ? b_addr  : a_addr;
    assign mem_din  = b_gnt ? b_wdata : a_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            burst_cnt <= '0;
            a_vld_p1  <= 1'b0;
            b_vld_p1  <= 1'b0;
        end else begin
            // p1: read issued this cycle returns next cycle to its own port
            a_vld_p1 <= a_gnt && !a_we;
            b_vld_p1 <= b_gnt && !b_we;
            if (a_gnt)
                last_b <= 1'b0;
            else if (b_gnt)
                last_b <= 1'b1;

            case (state)
                OWN_A: begin
                    if (!a_gnt || !a_lock || (b_req && cnt_inc == CNT_MAX)) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (b_req) begin
                        burst_cnt <= cnt_inc;
                    end
                end
                OWN_B: begin
                    if (!b_gnt || !b_lock || (a_req && cnt_inc == CNT_MAX)) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (a_req) begin
                        burst_cnt <= cnt_inc;
                    end
                end
                default: begin
                    // A one-beat limit with the other port waiting leaves no room to lock.
                    if (a_gnt && a_lock && !(b_req && MAX_BURST == 1)) begin
                        state     <= OWN_A;
                        burst_cnt <= CNT_W'(1);
                    end else if (b_gnt && b_lock && !(a_req && MAX_BURST == 1)) begin
                        state     <= OWN_B;
                        burst_cnt <= CNT_W'(1);
                    end else begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign a_rvalid = a_vld_p1;
    assign b_rvalid = b_vld_p1;
    assign a_rdata  = a_vld_p1 ? mem_dout : '0;
    assign b_rdata  = b_vld_p1 ? mem_dout : '0;

endmodule

// File: tb/tb_ram24_bus_arbiter.sv
// Bench for ram24_bus_arbiter: directed scenarios plus randomized traffic against an
// ownership/round-robin reference model and a shadow copy of the RAM.
module tb_ram24_bus_arbiter;
    localparam int AW = 14;
    localparam int DW = 24;
    localparam int MB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int n_vec = 0;
    int n_err = 0;

    ram24_bus_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Synchronous single-port RAM, read-before-write.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 4'b0000) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    // Reference model: owner 0=none 1=A 2=B, last winner, beats in current locked burst.
    int            m_own = 0, m_last = 2, m_beats = 0, m_pend = 0;
    logic [DW-1:0] m_pend_data = '0;
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    function automatic int mdl_grant();
        if (rst !== 1'b1) return 0;
        if (m_own == 1) return a_req ? 1 : (b_req ? 2 : 0);
        if (m_own == 2) return b_req ? 2 : (a_req ? 1 : 0);
        if (a_req && b_req) return (m_last == 2) ? 1 : 2;
        return a_req ? 1 : (b_req ? 2 : 0);
    endfunction

    always @(posedge clk) begin : model
        int   g;
        logic lk, oth;
        g = mdl_grant();
        if (rst !== 1'b1) begin
            m_own = 0; m_last = 2; m_beats = 0; m_pend = 0;
        end else begin
            lk = 1'b0; oth = 1'b0;
            if (g == 1) begin lk = a_lock; oth = b_req; end
            if (g == 2) begin lk = b_lock; oth = a_req; end
            m_pend = 0;
            if (g == 1) begin
                if (a_we) shadow[a_addr] = a_wdata;
                else begin m_pend = 1; m_pend_data = shadow[a_addr]; end
            end
            if (g == 2) begin
                if (b_we) shadow[b_addr] = b_wdata;
                else begin m_pend = 2; m_pend_data = shadow[b_addr]; end
            end
            if (g != 0) m_last = g;
            if (m_own == 0) begin
                if (g != 0 && lk && !(oth && MB == 1)) begin m_own = g; m_beats = 1; end
            end else if (g != m_own || !lk) begin
                m_own = 0; m_beats = 0;
            end else if (oth) begin
                m_beats++;
                if (m_beats >= MB) begin m_own = 0; m_beats = 0; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; a_req = 1'b1; b_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #4;
            n_vec++; if (a_gnt !== 1'b0) begin n_err++; $display("FAIL reset_a_gnt: got %b want 0", a_gnt); end
            n_vec++; if (b_gnt !== 1'b0) begin n_err++; $display("FAIL reset_b_gnt: got %b want 0", b_gnt); end
            n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
            n_vec++; if (mem_we !== 4'b0000) begin n_err++; $display("FAIL reset_mem_we: got %h want 0", mem_we); end
            n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_a_rvalid: got %b want 0", a_rvalid); end
            n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_b_rvalid: got %b want 0", b_rvalid); end
            tick();
        end
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_single_read();
        ram[14'h0010] = 24'h123456; shadow[14'h0010] = 24'h123456;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 14'h0010; b_req = 1'b0;
        #4;
        n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL read_a_gnt: got %b want 1", a_gnt); end
        n_vec++; if (mem_addr !== 14'h0010) begin n_err++; $display("FAIL read_mem_addr: got %h want 0010", mem_addr); end
        n_vec++; if (mem_we !== 4'b0000) begin n_err++; $display("FAIL read_mem_we: got %h want 0", mem_we); end
        tick();
        a_req = 1'b0;
        #4;
        n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL read_a_rvalid: got %b want 1", a_rvalid); end
        n_vec++; if (a_rdata !== 24'h123456) begin n_err++; $display("FAIL read_a_rdata: got %h want 123456", a_rdata); end
        n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL read_b_rvalid: got %b want 0", b_rvalid); end
        n_vec++; if (b_rdata !== 24'h0) begin n_err++; $display("FAIL read_b_rdata: got %h want 0", b_rdata); end
        tick();
    endtask

    task automatic test_tie();
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 14'h0030; a_wdata = 24'h0A0A0A;
        b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 14'h0031;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_vec++; if (a_gnt !== (i % 2 == 0)) begin n_err++; $display("FAIL tie_a_gnt[%0d]: got %b want %b", i, a_gnt, (i % 2 == 0)); end
            n_vec++; if (b_gnt !== (i % 2 == 1)) begin n_err++; $display("FAIL tie_b_gnt[%0d]: got %b want %b", i, b_gnt, (i % 2 == 1)); end
            n_vec++; if (mem_we !== ((i % 2 == 0) ? 4'b1111 : 4'b0000)) begin n_err++; $display("FAIL tie_mem_we[%0d]: got %h", i, mem_we); end
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_locked_burst();
        int bi = 0, cyc = 0, a_pos = -1, a_cnt = 0, b_before = -1, both = 0;
        logic ga, gb;
        b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 14'h0100; b_wdata = 24'hB00000;
        a_req = 1'b0;
        while (bi < 12 && cyc < 40) begin
            if (cyc == 1) begin a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 14'h0040; end
            #4;
            ga = a_gnt; gb = b_gnt;
            if (ga && gb) both++;
            tick();
            if (ga) begin a_cnt++; a_pos = cyc; b_before = bi; a_req = 1'b0; end
            if (gb) begin
                bi++;
                if (bi < 12) begin b_addr = 14'h0100 + AW'(bi); b_wdata = 24'hB00000 + DW'(bi); end
                else begin b_req = 1'b0; b_lock = 1'b0; end
            end
            cyc++;
        end
        n_vec++; if (bi != 12) begin n_err++; $display("FAIL burst_b_grants: got %0d want 12 in 40 cycles", bi); end
        n_vec++; if (b_before != 8) begin n_err++; $display("FAIL burst_b_before_a: got %0d want 8", b_before); end
        n_vec++; if (a_pos != 8) begin n_err++; $display("FAIL burst_a_cycle: got %0d want 8", a_pos); end
        n_vec++; if (a_cnt != 1) begin n_err++; $display("FAIL burst_a_grants: got %0d want 1", a_cnt); end
        n_vec++; if (both != 0) begin n_err++; $display("FAIL burst_double_gnt: got %0d want 0", both); end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (ram[14'h0100 + AW'(i)] !== 24'hB00000 + DW'(i)) begin
                n_err++; $display("FAIL burst_ram[%0d]: got %h want %h", i, ram[14'h0100 + AW'(i)], 24'hB00000 + DW'(i));
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_read_handoff();
        logic [DW-1:0] v0, v1;
        v0 = DW'($urandom); v1 = DW'($urandom);
        ram[14'h0020] = v0; shadow[14'h0020] = v0;
        ram[14'h0021] = v1; shadow[14'h0021] = v1;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 14'h0020; b_req = 1'b0;
        #4;
        n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL hand_a_gnt: got %b want 1", a_gnt); end
        tick();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 14'h0021;
        #4;
        n_vec++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL hand_b_gnt: got %b want 1", b_gnt); end
        n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL hand_a_rvalid: got %b want 1", a_rvalid); end
        n_vec++; if (a_rdata !== v0) begin n_err++; $display("FAIL hand_a_rdata: got %h want %h", a_rdata, v0); end
        n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL hand_b_rvalid0: got %b want 0", b_rvalid); end
        tick();
        b_req = 1'b0;
        #4;
        n_vec++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL hand_b_rvalid: got %b want 1", b_rvalid); end
        n_vec++; if (b_rdata !== v1) begin n_err++; $display("FAIL hand_b_rdata: got %h want %h", b_rdata, v1); end
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL hand_a_rvalid1: got %b want 0", a_rvalid); end
        n_vec++; if (a_rdata !== 24'h0) begin n_err++; $display("FAIL hand_a_rdata1: got %h want 0", a_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b1; a_addr = 14'h0200; b_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #4;
            n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL mid_beat%0d_gnt: got %b want 1", i + 1, a_gnt); end
            tick();
            a_addr = a_addr + 14'h1;
        end
        rst = 1'b0; b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 14'h0300;
        #4;
        n_vec++; if (a_gnt !== 1'b0) begin n_err++; $display("FAIL mid_rst_a_gnt: got %b want 0", a_gnt); end
        n_vec++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_mem_en: got %b want 0", mem_en); end
        tick();
        #4;
        n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_a_rvalid: got %b want 0", a_rvalid); end
        tick();
        rst = 1'b1; a_lock = 1'b0;
        #4;
        n_vec++; if (a_gnt !== 1'b1) begin n_err++; $display("FAIL mid_tie_a_gnt: got %b want 1", a_gnt); end
        n_vec++; if (b_gnt !== 1'b0) begin n_err++; $display("FAIL mid_tie_b_gnt: got %b want 0", b_gnt); end
        tick();
        #4;
        n_vec++; if (b_gnt !== 1'b1) begin n_err++; $display("FAIL mid_tie2_b_gnt: got %b want 1", b_gnt); end
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int   eg;
        logic ga, gb;
        logic [3:0] ewe;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (!a_req && $urandom_range(0, 2) != 0) begin
                a_req = 1'b1; a_we = 1'($urandom_range(0, 1)); a_lock = ($urandom_range(0, 3) != 0);
                a_addr = AW'($urandom_range(0, 31)); a_wdata = DW'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) != 0) begin
                b_req = 1'b1; b_we = 1'($urandom_range(0, 1)); b_lock = ($urandom_range(0, 3) != 0);
                b_addr = AW'($urandom_range(0, 31)); b_wdata = DW'($urandom);
            end
            #4;
            eg  = mdl_grant();
            ewe = ((eg == 1 && a_we) || (eg == 2 && b_we)) ? 4'b1111 : 4'b0000;
            n_vec++; if (a_gnt !== (eg == 1)) begin n_err++; $display("FAIL rnd_a_gnt c%0d: got %b want %b", c, a_gnt, (eg == 1)); end
            n_vec++; if (b_gnt !== (eg == 2)) begin n_err++; $display("FAIL rnd_b_gnt c%0d: got %b want %b", c, b_gnt, (eg == 2)); end
            n_vec++; if (mem_en !== (eg != 0)) begin n_err++; $display("FAIL rnd_mem_en c%0d: got %b want %b", c, mem_en, (eg != 0)); end
            n_vec++; if (mem_we !== ewe) begin n_err++; $display("FAIL rnd_mem_we c%0d: got %h want %h", c, mem_we, ewe); end
            n_vec++; if (mem_addr !== ((eg == 2) ? b_addr : a_addr)) begin n_err++; $display("FAIL rnd_mem_addr c%0d: got %h", c, mem_addr); end
            n_vec++; if (mem_din !== ((eg == 2) ? b_wdata : a_wdata)) begin n_err++; $display("FAIL rnd_mem_din c%0d: got %h", c, mem_din); end
            n_vec++; if (a_rvalid !== (m_pend == 1)) begin n_err++; $display("FAIL rnd_a_rvalid c%0d: got %b want %b", c, a_rvalid, (m_pend == 1)); end
            n_vec++; if (b_rvalid !== (m_pend == 2)) begin n_err++; $display("FAIL rnd_b_rvalid c%0d: got %b want %b", c, b_rvalid, (m_pend == 2)); end
            n_vec++; if (a_rdata !== ((m_pend == 1) ? m_pend_data : '0)) begin n_err++; $display("FAIL rnd_a_rdata c%0d: got %h", c, a_rdata); end
            n_vec++; if (b_rdata !== ((m_pend == 2) ? m_pend_data : '0)) begin n_err++; $display("FAIL rnd_b_rdata c%0d: got %h", c, b_rdata); end
            ga = a_gnt; gb = b_gnt;
            tick();
            if (ga) a_req = 1'b0;
            if (gb) b_req = 1'b0;
        end
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
        mem_dout = '0;
        for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; shadow[i] = '0; end
        test_reset();
        test_single_read();
        test_tie();
        test_locked_burst();
        test_read_handoff();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
